// File: rtl/operand_stage.sv
// ID/EX pipeline register: captures decoded instruction and rs1/rs2 operands,
// forwards from EX/MEM writers and inserts a bubble on unresolved RAW hazards.
module operand_stage #(
    parameter int XLEN   = 64,
    parameter int CTRL_W = 16,
    parameter bit FWD_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              id_valid_i,
    output logic              id_ready_o,
    input  logic [XLEN-1:0]   id_pc_i,
    input  logic [XLEN-1:0]   id_imm_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    input  logic [4:0]        id_rd_i,
    input  logic [4:0]        id_rs1_idx_i,
    input  logic [4:0]        id_rs2_idx_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic [XLEN-1:0]   rf_rs1_data_i,
    input  logic [XLEN-1:0]   rf_rs2_data_i,

    input  logic [4:0]        ex_rd_i,
    input  logic              ex_wr_en_i,
    input  logic              ex_is_load_i,
    input  logic [XLEN-1:0]   ex_result_i,

    input  logic [4:0]        mem_rd_i,
    input  logic              mem_wr_en_i,
    input  logic              mem_data_valid_i,
    input  logic [XLEN-1:0]   mem_data_i,

    input  logic              flush_i,
    input  logic              ex_ready_i,
    output logic              ex_valid_o,
    output logic [XLEN-1:0]   ex_pc_o,
    output logic [XLEN-1:0]   ex_imm_o,
    output logic [XLEN-1:0]   ex_rs1_data_o,
    output logic [XLEN-1:0]   ex_rs2_data_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic [4:0]        ex_rd_o,
    output logic              hazard_stall_o
);

    logic            advance;
    logic            ex_src_en;
    logic            rs1_ex_hit, rs1_mem_hit;
    logic            rs2_ex_hit, rs2_mem_hit;
    logic            rs1_haz, rs2_haz, hazard;
    logic [XLEN-1:0] rs1_sel, rs2_sel;

    assign advance   = ex_ready_i | ~ex_valid_o;
    // The EX writer only counts while this stage actually holds it.
    assign ex_src_en = ex_valid_o & ex_wr_en_i;

    assign rs1_ex_hit  = id_rs1_used_i & (id_rs1_idx_i != 5'd0) & ex_src_en
                       & (ex_rd_i == id_rs1_idx_i);
    assign rs1_mem_hit = id_rs1_used_i & (id_rs1_idx_i != 5'd0) & mem_wr_en_i
                       & (mem_rd_i == id_rs1_idx_i);
    assign rs2_ex_hit  = id_rs2_used_i & (id_rs2_idx_i != 5'd0) & ex_src_en
                       & (ex_rd_i == id_rs2_idx_i);
    assign rs2_mem_hit = id_rs2_used_i & (id_rs2_idx_i != 5'd0) & mem_wr_en_i
                       & (mem_rd_i == id_rs2_idx_i);

    generate
        if (FWD_EN) begin : g_fwd
            // EX result is not usable when it is a load or EX is stalled;
            // MEM data is only usable once final, and EX shadows MEM.
            assign rs1_haz = (rs1_ex_hit & (ex_is_load_i | ~ex_ready_i))
                           | (rs1_mem_hit & ~rs1_ex_hit & ~mem_data_valid_i);
            assign rs2_haz = (rs2_ex_hit & (ex_is_load_i | ~ex_ready_i))
                           | (rs2_mem_hit & ~rs2_ex_hit & ~mem_data_valid_i);

            always_comb begin
                rs1_sel = rf_rs1_data_i;
                if (id_rs1_idx_i == 5'd0)
                    rs1_sel = '0;
                else if (rs1_ex_hit)
                    rs1_sel = ex_result_i;
                else if (rs1_mem_hit)
                    rs1_sel = mem_data_i;
            end

            always_comb begin
                rs2_sel = rf_rs2_data_i;
                if (id_rs2_idx_i == 5'd0)
                    rs2_sel = '0;
                else if (rs2_ex_hit)
                    rs2_sel = ex_result_i;
                else if (rs2_mem_hit)
                    rs2_sel = mem_data_i;
            end
        end else begin : g_nofwd
            assign rs1_haz = rs1_ex_hit | rs1_mem_hit;
            assign rs2_haz = rs2_ex_hit | rs2_mem_hit;
            assign rs1_sel = (id_rs1_idx_i == 5'd0) ? '0 : rf_rs1_data_i;
            assign rs2_sel = (id_rs2_idx_i == 5'd0) ? '0 : rf_rs2_data_i;
        end
    endgenerate

    assign hazard         = rs1_haz | rs2_haz;
    assign hazard_stall_o = hazard & id_valid_i & ~flush_i;
    assign id_ready_o     = flush_i | (advance & ~hazard);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_valid_o    <= 1'b0;
            ex_pc_o       <= '0;
            ex_imm_o      <= '0;
            ex_rs1_data_o <= '0;
            ex_rs2_data_o <= '0;
            ex_ctrl_o     <= '0;
            ex_rd_o       <= '0;
        end else if (flush_i) begin
            ex_valid_o <= 1'b0;
        end else if (advance) begin
            if (hazard) begin
                ex_valid_o <= 1'b0;
            end else begin
                ex_valid_o <= id_valid_i;
                if (id_valid_i) begin
                    ex_pc_o       <= id_pc_i;
                    ex_imm_o      <= id_imm_i;
                    ex_rs1_data_o <= rs1_sel;
                    ex_rs2_data_o <= rs2_sel;
                    ex_ctrl_o     <= id_ctrl_i;
                    ex_rd_o       <= id_rd_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_operand_stage.sv
// Bench for operand_stage: a forwarding and a non-forwarding instance share
// stimulus and are compared each cycle against a writer-list reference model.
module tb_operand_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        id_valid_i;
    logic [63:0] id_pc_i, id_imm_i;
    logic [15:0] id_ctrl_i;
    logic [4:0]  id_rd_i, id_rs1_idx_i, id_rs2_idx_i;
    logic        id_rs1_used_i, id_rs2_used_i;
    logic [63:0] rf_rs1_data_i, rf_rs2_data_i;
    logic [4:0]  ex_rd_i;
    logic        ex_wr_en_i, ex_is_load_i;
    logic [63:0] ex_result_i;
    logic [4:0]  mem_rd_i;
    logic        mem_wr_en_i, mem_data_valid_i;
    logic [63:0] mem_data_i;
    logic        flush_i, ex_ready_i;

    logic        rdy_w   [2];
    logic        stall_w [2];
    logic        v_w     [2];
    logic [63:0] pc_w    [2];
    logic [63:0] imm_w   [2];
    logic [63:0] rs1_w   [2];
    logic [63:0] rs2_w   [2];
    logic [15:0] ctrl_w  [2];
    logic [4:0]  rd_w    [2];

    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    operand_stage #(.XLEN(64), .CTRL_W(16), .FWD_EN(1'b1)) u_fwd (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .id_valid_i(id_valid_i), .id_ready_o(rdy_w[0]),
        .id_pc_i(id_pc_i), .id_imm_i(id_imm_i), .id_ctrl_i(id_ctrl_i), .id_rd_i(id_rd_i),
        .id_rs1_idx_i(id_rs1_idx_i), .id_rs2_idx_i(id_rs2_idx_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .rf_rs1_data_i(rf_rs1_data_i), .rf_rs2_data_i(rf_rs2_data_i),
        .ex_rd_i(ex_rd_i), .ex_wr_en_i(ex_wr_en_i), .ex_is_load_i(ex_is_load_i),
        .ex_result_i(ex_result_i),
        .mem_rd_i(mem_rd_i), .mem_wr_en_i(mem_wr_en_i), .mem_data_valid_i(mem_data_valid_i),
        .mem_data_i(mem_data_i),
        .flush_i(flush_i), .ex_ready_i(ex_ready_i), .ex_valid_o(v_w[0]),
        .ex_pc_o(pc_w[0]), .ex_imm_o(imm_w[0]), .ex_rs1_data_o(rs1_w[0]),
        .ex_rs2_data_o(rs2_w[0]), .ex_ctrl_o(ctrl_w[0]), .ex_rd_o(rd_w[0]),
        .hazard_stall_o(stall_w[0])
    );

    operand_stage #(.XLEN(64), .CTRL_W(16), .FWD_EN(1'b0)) u_nofwd (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .id_valid_i(id_valid_i), .id_ready_o(rdy_w[1]),
        .id_pc_i(id_pc_i), .id_imm_i(id_imm_i), .id_ctrl_i(id_ctrl_i), .id_rd_i(id_rd_i),
        .id_rs1_idx_i(id_rs1_idx_i), .id_rs2_idx_i(id_rs2_idx_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .rf_rs1_data_i(rf_rs1_data_i), .rf_rs2_data_i(rf_rs2_data_i),
        .ex_rd_i(ex_rd_i), .ex_wr_en_i(ex_wr_en_i), .ex_is_load_i(ex_is_load_i),
        .ex_result_i(ex_result_i),
        .mem_rd_i(mem_rd_i), .mem_wr_en_i(mem_wr_en_i), .mem_data_valid_i(mem_data_valid_i),
        .mem_data_i(mem_data_i),
        .flush_i(flush_i), .ex_ready_i(ex_ready_i), .ex_valid_o(v_w[1]),
        .ex_pc_o(pc_w[1]), .ex_imm_o(imm_w[1]), .ex_rs1_data_o(rs1_w[1]),
        .ex_rs2_data_o(rs2_w[1]), .ex_ctrl_o(ctrl_w[1]), .ex_rd_o(rd_w[1]),
        .hazard_stall_o(stall_w[1])
    );

    typedef struct {
        logic        v;
        logic [63:0] pc, imm, a, b;
        logic [15:0] ctrl;
        logic [4:0]  rd;
    } st_t;

    st_t  m [2];
    logic obs_rdy   [2];
    logic obs_stall [2];

    task automatic chk(input string tag, input int k, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    // Writer list ordered youngest first: 0 = EX, 1 = MEM. Returns the
    // youngest writer producing register idx, or -1 when none does.
    function automatic int youngest_writer(int k, logic used, logic [4:0] idx);
        logic       en [2];
        logic [4:0] rd [2];
        en[0] = m[k].v & ex_wr_en_i;  rd[0] = ex_rd_i;
        en[1] = mem_wr_en_i;          rd[1] = mem_rd_i;
        if (!used || idx == 5'd0) return -1;
        for (int w = 0; w < 2; w++)
            if (en[w] && rd[w] == idx) return w;
        return -1;
    endfunction

    function automatic logic [63:0] ref_operand(int k, logic used, logic [4:0] idx,
                                                logic [63:0] rf);
        int w;
        if (idx == 5'd0) return 64'd0;
        w = youngest_writer(k, used, idx);
        if (k == 0 && w == 0) return ex_result_i;
        if (k == 0 && w == 1) return mem_data_i;
        return rf;
    endfunction

    function automatic bit ref_blocked(int k, logic used, logic [4:0] idx);
        int w;
        w = youngest_writer(k, used, idx);
        if (k == 1) return w >= 0;
        if (w == 0) return ex_is_load_i || !ex_ready_i;
        if (w == 1) return !mem_data_valid_i;
        return 0;
    endfunction

    task automatic step();
        st_t nx [2];
        #1;
        for (int k = 0; k < 2; k++) begin
            bit h, adv;
            h   = ref_blocked(k, id_rs1_used_i, id_rs1_idx_i)
                | ref_blocked(k, id_rs2_used_i, id_rs2_idx_i);
            adv = ex_ready_i || !m[k].v;
            chk("id_ready", k, rdy_w[k], flush_i | (adv & !h));
            chk("hazard_stall", k, stall_w[k], h & id_valid_i & !flush_i);
            obs_rdy[k]   = rdy_w[k];
            obs_stall[k] = stall_w[k];
            nx[k] = m[k];
            if (flush_i) nx[k].v = 1'b0;
            else if (adv && h) nx[k].v = 1'b0;
            else if (adv) begin
                nx[k].v = id_valid_i;
                if (id_valid_i) begin
                    nx[k].pc   = id_pc_i;
                    nx[k].imm  = id_imm_i;
                    nx[k].ctrl = id_ctrl_i;
                    nx[k].rd   = id_rd_i;
                    nx[k].a    = ref_operand(k, id_rs1_used_i, id_rs1_idx_i, rf_rs1_data_i);
                    nx[k].b    = ref_operand(k, id_rs2_used_i, id_rs2_idx_i, rf_rs2_data_i);
                end
            end
        end
        @(posedge clk_i);
        #1;
        for (int k = 0; k < 2; k++) begin
            m[k] = nx[k];
            chk("ex_valid", k, v_w[k], m[k].v);
            if (m[k].v) begin
                chk("ex_pc", k, pc_w[k], m[k].pc);
                chk("ex_imm", k, imm_w[k], m[k].imm);
                chk("ex_ctrl", k, ctrl_w[k], m[k].ctrl);
                chk("ex_rd", k, rd_w[k], m[k].rd);
                chk("ex_rs1", k, rs1_w[k], m[k].a);
                chk("ex_rs2", k, rs2_w[k], m[k].b);
            end
        end
    endtask

    task automatic idle();
        id_valid_i = 0; id_pc_i = 0; id_imm_i = 0; id_ctrl_i = 0; id_rd_i = 0;
        id_rs1_idx_i = 0; id_rs2_idx_i = 0; id_rs1_used_i = 0; id_rs2_used_i = 0;
        rf_rs1_data_i = 0; rf_rs2_data_i = 0;
        ex_rd_i = 0; ex_wr_en_i = 0; ex_is_load_i = 0; ex_result_i = 0;
        mem_rd_i = 0; mem_wr_en_i = 0; mem_data_valid_i = 1; mem_data_i = 0;
        flush_i = 0; ex_ready_i = 1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m[k].v = 0; m[k].pc = 0; m[k].imm = 0; m[k].a = 0; m[k].b = 0;
            m[k].ctrl = 0; m[k].rd = 0;
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_valid"}, k, v_w[k], 0);
            chk({tag, "_pc"}, k, pc_w[k], 0);
            chk({tag, "_imm"}, k, imm_w[k], 0);
            chk({tag, "_rs1"}, k, rs1_w[k], 0);
            chk({tag, "_rs2"}, k, rs2_w[k], 0);
            chk({tag, "_ctrl"}, k, ctrl_w[k], 0);
            chk({tag, "_rd"}, k, rd_w[k], 0);
        end
    endtask

    logic [63:0] held_pc;

    initial begin
        idle();
        rst_ni = 0;
        model_reset();
        #12;
        chk_zero("rst");
        chk("rst_ready", 0, rdy_w[0], 1);
        chk("rst_stall", 0, stall_w[0], 0);
        rst_ni = 1;

        // ADDI x5 enters EX
        id_valid_i = 1; id_pc_i = 64'h100; id_rd_i = 5; id_ctrl_i = 16'h0013;
        step();
        // ADD reads x5 from EX
        ex_rd_i = 5; ex_wr_en_i = 1; ex_result_i = 64'h10;
        id_pc_i = 64'h104; id_rd_i = 6; id_rs1_idx_i = 5; id_rs1_used_i = 1;
        rf_rs1_data_i = 0;
        step();
        chk("exfwd_rs1", 0, rs1_w[0], 64'h10);
        chk("exfwd_stall", 0, obs_stall[0], 0);

        // load-use on rs2 = x7
        ex_rd_i = 7; ex_is_load_i = 1; ex_wr_en_i = 1;
        id_pc_i = 64'h108; id_rs1_used_i = 0; id_rs2_idx_i = 7; id_rs2_used_i = 1;
        step();
        chk("lu_stall", 0, obs_stall[0], 1);
        chk("lu_ready", 0, obs_rdy[0], 0);
        chk("lu_bubble", 0, v_w[0], 0);
        ex_wr_en_i = 0; ex_is_load_i = 0;
        mem_rd_i = 7; mem_wr_en_i = 1; mem_data_valid_i = 1; mem_data_i = 64'hDEADBEEF;
        step();
        chk("lu_rs2", 0, rs2_w[0], 64'hDEADBEEF);
        chk("lu_valid", 0, v_w[0], 1);

        // x0 never forwards
        ex_rd_i = 0; ex_wr_en_i = 1; mem_rd_i = 0; mem_wr_en_i = 1;
        id_pc_i = 64'h10C; id_rs1_idx_i = 0; id_rs1_used_i = 1; id_rs2_used_i = 0;
        rf_rs1_data_i = 64'hFFFF;
        step();
        chk("x0_rs1", 0, rs1_w[0], 0);
        chk("x0_stall", 0, obs_stall[0], 0);
        chk("x0_stall", 1, obs_stall[1], 0);
        // EX beats MEM for x3
        ex_rd_i = 3; mem_rd_i = 3; ex_result_i = 64'h1; mem_data_i = 64'h2;
        id_pc_i = 64'h110; id_rs1_idx_i = 3;
        step();
        chk("prio_rs1", 0, rs1_w[0], 64'h1);

        // backpressure then flush while stalled
        ex_wr_en_i = 0; mem_wr_en_i = 0; id_rs1_used_i = 0;
        step();
        held_pc = pc_w[0];
        ex_ready_i = 0; id_pc_i = 64'h200;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_pc", 0, pc_w[0], held_pc);
            chk("bp_valid", 0, v_w[0], 1);
        end
        flush_i = 1;
        step();
        chk("flush_ready", 0, obs_rdy[0], 1);
        chk("flush_valid", 0, v_w[0], 0);
        flush_i = 0; ex_ready_i = 1;

        // no-forwarding instance stalls on MEM writer of x9
        mem_rd_i = 9; mem_wr_en_i = 1; mem_data_i = 64'h55;
        id_pc_i = 64'h300; id_rs1_idx_i = 9; id_rs1_used_i = 1; rf_rs1_data_i = 64'h99;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("nofwd_stall", 1, obs_stall[1], 1);
            chk("nofwd_bubble", 1, v_w[1], 0);
        end
        mem_wr_en_i = 0;
        step();
        chk("nofwd_valid", 1, v_w[1], 1);
        chk("nofwd_rs1", 1, rs1_w[1], 64'h99);

        // reset mid-stream
        step();
        #2;
        rst_ni = 0;
        #1;
        model_reset();
        chk_zero("midrst");
        @(posedge clk_i);
        #1;
        chk("midrst_hold", 0, v_w[0], 0);
        #2;
        rst_ni = 1;
        id_pc_i = 64'h400; id_rs1_used_i = 0;
        step();
        chk("postrst_valid", 0, v_w[0], 1);
        chk("postrst_pc", 0, pc_w[0], 64'h400);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            id_valid_i       = ($urandom_range(3) != 0);
            id_pc_i          = {$urandom(), $urandom()};
            id_imm_i         = {$urandom(), $urandom()};
            id_ctrl_i        = 16'($urandom());
            id_rd_i          = 5'($urandom_range(3));
            id_rs1_idx_i     = 5'($urandom_range(3));
            id_rs2_idx_i     = 5'($urandom_range(3));
            id_rs1_used_i    = 1'($urandom_range(1));
            id_rs2_used_i    = 1'($urandom_range(1));
            rf_rs1_data_i    = {$urandom(), $urandom()};
            rf_rs2_data_i    = {$urandom(), $urandom()};
            ex_rd_i          = 5'($urandom_range(3));
            ex_wr_en_i       = 1'($urandom_range(1));
            ex_is_load_i     = ($urandom_range(9) < 3);
            ex_result_i      = {$urandom(), $urandom()};
            mem_rd_i         = 5'($urandom_range(3));
            mem_wr_en_i      = 1'($urandom_range(1));
            mem_data_valid_i = ($urandom_range(9) < 7);
            mem_data_i       = {$urandom(), $urandom()};
            flush_i          = ($urandom_range(9) == 0);
            ex_ready_i       = ($urandom_range(9) < 7);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
